// File: rtl/data_mem_responder_pkg.sv
// Shared size codes, FSM encoding and byte-lane helpers for data_mem_responder.
// Offset handling depends on DMEM_MISALIGN_EN (misaligned access detection).
package data_mem_responder_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  // size[1] set means word regardless of size[0]
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size[1])       return off != 2'b00;
    if (size == SZ_H)  return off[0];
    return 1'b0;
  endfunction

  function automatic logic [1:0] load_offset(input logic [1:0] size, input logic [1:0] off);
`ifdef DMEM_MISALIGN_EN
    if (size == 2'b11) return off;
    return off;
`else
    if (size[1])       return 2'b00;
    if (size == SZ_H)  return {off[1], 1'b0};
    return off;
`endif
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    if (size[1])       return 4'b1111;
    if (size == SZ_H)  return off[1] ? 4'b1100 : 4'b0011;
    return 4'b0001 << off;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    if (size[1])       return d;
    if (size == SZ_H)  return {2{d[15:0]}};
    return {4{d[7:0]}};
  endfunction

  function automatic logic [31:0] shift_down(input logic [31:0] word, input logic [1:0] off);
    return word >> {off, 3'b000};
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store strobe bus between the pipeline (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
  logic        i_stb;
  logic        i_wr_en;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic [1:0]  i_size;
  logic        o_rd_ack;
  logic [31:0] o_read_data;
  logic        o_misalign;

  modport master (
    output i_stb, i_wr_en, i_addr, i_wr_data, i_size,
    input  o_rd_ack, o_read_data, o_misalign
  );

  modport slave (
    input  i_stb, i_wr_en, i_addr, i_wr_data, i_size,
    output o_rd_ack, o_read_data, o_misalign
  );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// dmem_array: 32-bit synchronous RAM with byte-lane write enables and a
// registered, enabled read port. Not reset.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [2**ADDR_W];

  // Read sees the pre-write contents when both hit the same word on one edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: posted byte/half/word stores, loads acked after
// LATENCY cycles with right-justified data. Optional feature: DMEM_MISALIGN_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

  dm_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  word_p0;
  logic [1:0]         off_p0;
  logic [1:0]         rd_off_p1;
  logic               rd_vld_p1;
  logic [31:0]        rd_data_p1;

  logic               accept;
  logic               rd_en;
  logic [ADDR_W-1:0]  req_word;
  logic [1:0]         req_off;
  logic [ADDR_W-1:0]  rd_word;
  logic [1:0]         rd_off;
  logic [3:0]         we;
  logic               unused_addr;

  assign unused_addr = ^bus.i_addr[31:ADDR_W+2];

  assign accept   = (state == DM_IDLE) && bus.i_stb;
  assign req_word = bus.i_addr[ADDR_W+1:2];
  assign req_off  = load_offset(bus.i_size, bus.i_addr[1:0]);

  // With LATENCY==1 RESP is entered on the accept edge, before the address latch
  assign rd_word = (state == DM_IDLE) ? req_word : word_p0;
  assign rd_off  = (state == DM_IDLE) ? req_off  : off_p0;
  assign rd_en   = (accept && (LATENCY == 1)) || ((state == DM_WAIT) && (cnt == '0));

`ifdef DMEM_MISALIGN_EN
  logic misalign_q;
  logic misalign_hit;

  assign misalign_hit = (bus.i_wr_en || accept) && is_misaligned(bus.i_size, bus.i_addr[1:0]);
  assign we = (bus.i_wr_en && !is_misaligned(bus.i_size, bus.i_addr[1:0]))
              ? lane_en(bus.i_size, bus.i_addr[1:0]) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n)            misalign_q <= 1'b0;
    else if (misalign_hit) misalign_q <= 1'b1;
  end

  assign bus.o_misalign = misalign_q;
`else
  assign we = bus.i_wr_en ? lane_en(bus.i_size, bus.i_addr[1:0]) : 4'b0000;
  assign bus.o_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= DM_IDLE;
      cnt       <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      case (state)
        DM_IDLE: begin
          if (bus.i_stb) begin
            if (LATENCY == 1) begin
              state <= DM_RESP;
            end else begin
              state <= DM_WAIT;
              cnt   <= CNT_W'(CNT_INIT);
            end
          end
        end
        DM_WAIT: begin
          if (cnt == '0) state <= DM_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        DM_RESP: state <= DM_IDLE;
        default: state <= DM_IDLE;
      endcase
      if (rd_en) rd_vld_p1 <= 1'b1;
    end
  end

  // p0: request latch at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      word_p0 <= req_word;
      off_p0  <= req_off;
    end
    if (rd_en) rd_off_p1 <= rd_off;
  end

  // p1: registered array read, aligned down to the addressed byte
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we      (we),
    .wr_addr (req_word),
    .wr_data (lane_data(bus.i_size, bus.i_wr_data)),
    .rd_en   (rd_en),
    .rd_addr (rd_word),
    .rd_data (rd_data_p1)
  );

  assign bus.o_read_data = rd_vld_p1 ? shift_down(rd_data_p1, rd_off_p1) : 32'h0;
  assign bus.o_rd_ack    = (state == DM_RESP) || ((state == DM_IDLE) && !bus.i_stb);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table plus reset,
// LATENCY=1 and misalignment sequences. Honors DMEM_MISALIGN_EN.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus_a();
  data_mem_responder_if bus_b();

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  typedef struct {
    bit          is_store;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[14];

  task automatic drive(input bit b, input logic stb, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz);
    if (b) begin
      bus_b.i_stb = stb; bus_b.i_wr_en = wr; bus_b.i_addr = a; bus_b.i_wr_data = d; bus_b.i_size = sz;
    end else begin
      bus_a.i_stb = stb; bus_a.i_wr_en = wr; bus_a.i_addr = a; bus_a.i_wr_data = d; bus_a.i_size = sz;
    end
  endtask

  function automatic logic get_ack(input bit b);
    return b ? bus_b.o_rd_ack : bus_a.o_rd_ack;
  endfunction
  function automatic logic [31:0] get_data(input bit b);
    return b ? bus_b.o_read_data : bus_a.o_read_data;
  endfunction
  function automatic logic get_mis(input bit b);
    return b ? bus_b.o_misalign : bus_a.o_misalign;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic store(input bit b, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk); drive(b, 1'b0, 1'b1, a, d, sz);
    @(negedge clk); drive(b, 1'b0, 1'b0, a, d, sz);
  endtask

  // Called #1 after the negedge of the first i_stb cycle; counts stall cycles
  task automatic wait_resp(input bit b, input int lat, input string name);
    int stalls;
    logic [31:0] req;
    stalls = 0;
    while (get_ack(b) !== 1'b1 && stalls < 50) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (get_ack(b) !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s no ack after %0d cycles", name, stalls);
    end else begin
      check({name, "_stall"}, 32'(stalls), 32'(lat));
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL %s ack with empty scoreboard actual=0x%08h", name, get_data(b));
      end else begin
        req = sb.pop_front();
        check(name, get_data(b), req);
      end
    end
  endtask

  task automatic load(input bit b, input logic [31:0] a, input logic [1:0] sz, input int lat,
                      input logic [31:0] exp, input string name);
    sb.push_back(exp);
    @(negedge clk); drive(b, 1'b1, 1'b0, a, 32'h0, sz); #1;
    wait_resp(b, lat, name);
    drive(b, 1'b0, 1'b0, a, 32'h0, sz);
  endtask

  initial begin
    tbl[0]  = '{1'b1, SZ_W, 32'h0000_0010, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b0, SZ_W, 32'h0000_0010, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, SZ_B, 32'h0000_0013, 32'h0000_00AA};
    tbl[3]  = '{1'b0, SZ_B, 32'h0000_0013, 32'h0000_00AA};
    tbl[4]  = '{1'b0, SZ_W, 32'h0000_0010, 32'hAAAD_BEEF};
    tbl[5]  = '{1'b1, SZ_H, 32'h0000_0020, 32'h0000_5678};
    tbl[6]  = '{1'b1, SZ_H, 32'h0000_0022, 32'h0000_1234};
    tbl[7]  = '{1'b0, SZ_H, 32'h0000_0022, 32'h0000_1234};
    tbl[8]  = '{1'b0, SZ_H, 32'h0000_0020, 32'h1234_5678};
    tbl[9]  = '{1'b0, SZ_B, 32'h0000_0011, 32'h00AA_ADBE};
    tbl[10] = '{1'b0, SZ_H, 32'h0000_0012, 32'h0000_AAAD};
    tbl[11] = '{1'b1, SZ_W, 32'h0000_1010, 32'h0BAD_F00D};
    tbl[12] = '{1'b0, SZ_W, 32'h0000_0010, 32'h0BAD_F00D};
    tbl[13] = '{1'b0, SZ_B, 32'h0000_0012, 32'h0000_0BAD};

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SZ_W);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, SZ_W);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ack", 32'(get_ack(1'b0)), 32'h1);
    check("reset_data", get_data(1'b0), 32'h0);
    check("reset_misalign", 32'(get_mis(1'b0)), 32'h0);
    check("reset_data_b", get_data(1'b1), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_store) store(1'b0, tbl[i].addr, tbl[i].data, tbl[i].size);
      else load(1'b0, tbl[i].addr, tbl[i].size, 2, tbl[i].data, $sformatf("vec%0d", i));
    end

    // Reset with a load already requested; array contents survive reset
    store(1'b0, 32'h40, 32'hCAFE_F00D, SZ_W);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, SZ_W);
    @(negedge clk); @(negedge clk); #1;
    check("rst_stb_ack", 32'(get_ack(1'b0)), 32'h0);
    check("rst_stb_data", get_data(1'b0), 32'h0);
    check("rst_stb_misalign", 32'(get_mis(1'b0)), 32'h0);
    rst_n = 1'b1;
    sb.push_back(32'hCAFE_F00D);
    wait_resp(1'b0, 2, "rst_stb_load");
    drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, SZ_W);

    // Reset while in WAIT abandons the load
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, SZ_W);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, SZ_W);
    @(negedge clk); #1;
    check("wait_rst_ack", 32'(get_ack(1'b0)), 32'h1);
    check("wait_rst_data", get_data(1'b0), 32'h0);
    rst_n = 1'b1;
    load(1'b0, 32'h10, SZ_W, 2, 32'h0BAD_F00D, "post_rst_load");

    // LATENCY=1 instance
    store(1'b1, 32'h8, 32'h1122_3344, SZ_W);
    load(1'b1, 32'h8, SZ_W, 1, 32'h1122_3344, "b_word");
    load(1'b1, 32'hA, SZ_H, 1, 32'h0000_1122, "b_half");
    load(1'b1, 32'h9, SZ_B, 1, 32'h0011_2233, "b_byte");

    store(1'b0, 32'h30, 32'h0102_0304, SZ_W);
    store(1'b0, 32'h31, 32'h5555_5555, SZ_W);
`ifdef DMEM_MISALIGN_EN
    check("mis_set", 32'(get_mis(1'b0)), 32'h1);
    load(1'b0, 32'h30, SZ_W, 2, 32'h0102_0304, "mis_store_dropped");
    load(1'b0, 32'h11, SZ_H, 2, 32'h000B_ADF0, "mis_half_load");
    check("mis_sticky", 32'(get_mis(1'b0)), 32'h1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); #1;
    check("mis_cleared", 32'(get_mis(1'b0)), 32'h0);
    rst_n = 1'b1;
`else
    check("mis_tied", 32'(get_mis(1'b0)), 32'h0);
    load(1'b0, 32'h30, SZ_W, 2, 32'h5555_5555, "align_word_store");
    load(1'b0, 32'h13, SZ_H, 2, 32'h0000_0BAD, "align_half_load");
    load(1'b0, 32'h12, SZ_W, 2, 32'h0BAD_F00D, "align_word_load");
`endif

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
